imem_arbiter: RTL

// - Shares one single-port 128x32 word-addressed memory between two requesters.
// - Port I: instruction fetch, read-only. Port D: data stage, read/write.
// - Issues at most one access per cycle. Read data returns exactly one cycle after grant.
// - Sits between the pipeline IF/MEM stages and the memory array. Owns the array's address, write-enable and write-data.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_prio_sel.sv | 46 ++++
 rtl/imem_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
// Holds array geometry, starvation limit and the response-tag encoding.
package imem_pkg;

    localparam int DEPTH        = 128;
    localparam int AW           = 7;
    localparam int STARVE_LIMIT = 3;
    localparam int SW           = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } tag_t;

    // Any address bit at or above AW means the word lies outside the array.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return (addr >> AW) == 32'd0;
    endfunction

endpackage

// File: rtl/imem_prio_sel.sv
// Grant selection between fetch (I) and data (D) ports with a starvation guard:
// D has priority, but I is force-granted after losing STARVE_LIMIT cycles in a row.
module imem_prio_sel
    import imem_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic i_valid,
    input  logic d_valid,
    output tag_t grant
);

    logic [SW-1:0] starve_cnt_reg;
    logic [SW-1:0] starve_cnt_next;
    logic          i_starved;

    assign i_starved = (starve_cnt_reg == SW'(STARVE_LIMIT));

    always_comb begin
        grant = TAG_NONE;
        if (!srst) begin
            if (i_valid && (!d_valid || i_starved)) begin
                grant = TAG_I;
            end else if (d_valid) begin
                grant = TAG_D;
            end
        end
    end

    // Count only while I is actually waiting; any I grant or idle I resets the streak.
    always_comb begin
        starve_cnt_next = '0;
        if (i_valid && (grant != TAG_I)) begin
            starve_cnt_next = i_starved ? starve_cnt_reg : starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port 128x32 memory arbiter between instruction fetch and data stage.
// One access per cycle; response returns on the requesting port one cycle after grant.
module imem_arbiter
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    input  logic [31:0]   i_addr,
    output logic          i_req_ready,
    output logic          i_rsp_valid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req_valid,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_req_ready,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    tag_t        grant;
    tag_t        tag_reg;
    logic        err_reg;
    logic        wr_reg;
    logic [31:0] sel_addr;
    logic        sel_err;
    logic        rsp_live;

    imem_prio_sel u_prio_sel (
        .clk     (clk),
        .srst    (rst),
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .grant   (grant)
    );

    assign i_req_ready = (grant == TAG_I);
    assign d_req_ready = (grant == TAG_D);

    always_comb begin
        sel_addr  = (grant == TAG_D) ? d_addr : i_addr;
        sel_err   = !addr_in_range(sel_addr);
        mem_addr  = sel_addr[AW-1:0];
        mem_we    = (grant == TAG_D) && d_we && !sel_err;
        mem_wdata = d_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_reg <= TAG_NONE;
            err_reg <= 1'b0;
            wr_reg  <= 1'b0;
        end else begin
            tag_reg <= grant;
            err_reg <= (grant != TAG_NONE) && sel_err;
            wr_reg  <= (grant == TAG_D) && d_we;
        end
    end

    // A response already tagged when reset arrives must not reach the pipeline.
    assign rsp_live = !rst;

    always_comb begin
        i_rsp_valid = rsp_live && (tag_reg == TAG_I);
        i_err       = i_rsp_valid && err_reg;
        i_rdata     = (i_rsp_valid && !err_reg) ? mem_rdata : '0;
        d_rsp_valid = rsp_live && (tag_reg == TAG_D);
        d_err       = d_rsp_valid && err_reg;
        d_rdata     = (d_rsp_valid && !err_reg && !wr_reg) ? mem_rdata : '0;
    end

endmodule
